touch_channel_scheduler: RTL and testbench

- Sequences the touchpad SPI conversion engine through repeated Z, X, Y conversion frames.
- For each channel, issues the channel command SETTLE_CONV+1 times, discards the settling results and keeps the last result.
- Gates X/Y publication on a Z pressure threshold.
- Drives per-channel valid strobes into the downstream averagers and the morse keying logic.

---
 rtl/touch_channel_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_touch_channel_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_channel_scheduler.sv
// Sequences Z -> X -> Y touch conversions through the SPI conversion engine and publishes kept samples.
// Optional build macro TOUCH_SCALE_EN: X/Y samples carry offset-and-shift scaled coordinates.
module touch_channel_scheduler #(
    parameter int unsigned SETTLE_CONV = 7,
    parameter logic [11:0] Z_THRESH    = 12'h100,
    parameter int unsigned TIMEOUT     = 1023,
    parameter logic [7:0]  CMD_Z       = 8'hB3,
    parameter logic [7:0]  CMD_X       = 8'hD3,
    parameter logic [7:0]  CMD_Y       = 8'h93
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic        enable,
    output logic        xfer_start,
    output logic [7:0]  xfer_cmd,
    input  logic        xfer_busy,
    input  logic        xfer_done,
    input  logic [11:0] xfer_data,
    output logic [11:0] z_sample,
    output logic        z_valid,
    output logic [11:0] x_sample,
    output logic        x_valid,
    output logic [11:0] y_sample,
    output logic        y_valid,
    output logic        touched,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    CNT_LAST = 4'(SETTLE_CONV);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SAMPLE} state_t;
    typedef enum logic [1:0] {CH_Z, CH_X, CH_Y} chan_t;

    state_t        state_q, state_d;
    chan_t         chan_q, chan_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [11:0]   kept_q;
    logic          start_c;
    logic          latch_c;
    logic          tmo_fire_c;

`ifdef TOUCH_SCALE_EN
    function automatic logic [11:0] scale_x(input logic [11:0] raw);
        return (raw < 12'd145) ? 12'd25 : ((raw - 12'd145) >> 2) + 12'd25;
    endfunction

    function automatic logic [11:0] scale_y(input logic [11:0] raw);
        return (raw < 12'd95) ? 12'd20 : ((raw - 12'd95) >> 3) + 12'd20;
    endfunction
`else
    function automatic logic [11:0] scale_x(input logic [11:0] raw);
        return raw;
    endfunction

    function automatic logic [11:0] scale_y(input logic [11:0] raw);
        return raw;
    endfunction
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= CH_Z;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        start_c    = 1'b0;
        latch_c    = 1'b0;
        tmo_fire_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ISSUE;
                    chan_d  = CH_Z;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (!xfer_busy) begin
                    start_c = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A done in the same cycle as the timeout boundary takes priority.
                if (xfer_done) begin
                    if (cnt_q == CNT_LAST) begin
                        latch_c = 1'b1;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_fire_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = ISSUE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SAMPLE: begin
                cnt_d   = '0;
                state_d = ISSUE;
                case (chan_q)
                    CH_Z:    chan_d = CH_X;
                    CH_X:    chan_d = CH_Y;
                    default: begin
                        chan_d  = CH_Z;
                        state_d = enable ? ISSUE : IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // The start strobe is masked while reset is held so the reset cycle never launches a transfer.
    assign xfer_start = start_c && !rst;

    always_comb begin
        case (chan_q)
            CH_X:    xfer_cmd = CMD_X;
            CH_Y:    xfer_cmd = CMD_Y;
            default: xfer_cmd = CMD_Z;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            kept_q      <= '0;
            z_sample    <= '0;
            x_sample    <= '0;
            y_sample    <= '0;
            z_valid     <= 1'b0;
            x_valid     <= 1'b0;
            y_valid     <= 1'b0;
            touched     <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            z_valid     <= 1'b0;
            x_valid     <= 1'b0;
            y_valid     <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= tmo_fire_c;
            if (latch_c) begin
                kept_q <= xfer_data;
            end
            if (state_q == SAMPLE) begin
                case (chan_q)
                    CH_Z: begin
                        z_sample <= kept_q;
                        z_valid  <= 1'b1;
                        touched  <= (kept_q >= Z_THRESH);
                    end
                    CH_X: begin
                        if (touched) begin
                            x_sample <= scale_x(kept_q);
                            x_valid  <= 1'b1;
                        end
                    end
                    default: begin
                        if (touched) begin
                            y_sample <= scale_y(kept_q);
                            y_valid  <= 1'b1;
                        end
                        frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_touch_channel_scheduler.sv
// Directed bench for touch_channel_scheduler: a 5-cycle engine model, a frame vector table and corner sequences.
module tb_touch_channel_scheduler;

    logic        cclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        xfer_busy = 1'b0;
    logic        xfer_start;
    logic [7:0]  xfer_cmd;
    logic        xfer_done;
    logic [11:0] xfer_data;
    logic [11:0] z_sample, x_sample, y_sample;
    logic        z_valid, x_valid, y_valid, touched, frame_done, timeout_err;

    logic        eng_done = 1'b0;
    logic [11:0] eng_data = '0;
    logic        stray_done = 1'b0;
    logic [11:0] stray_data = '0;
    logic [11:0] data_z = '0, data_x = '0, data_y = '0;
    logic        withhold_x3 = 1'b0;

    assign xfer_done = eng_done | stray_done;
    assign xfer_data = stray_done ? stray_data : eng_data;

    touch_channel_scheduler dut (
        .cclk(cclk), .rst(rst), .enable(enable),
        .xfer_start(xfer_start), .xfer_cmd(xfer_cmd), .xfer_busy(xfer_busy),
        .xfer_done(xfer_done), .xfer_data(xfer_data),
        .z_sample(z_sample), .z_valid(z_valid),
        .x_sample(x_sample), .x_valid(x_valid),
        .y_sample(y_sample), .y_valid(y_valid),
        .touched(touched), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observation at the falling edge, away from the active edge.
    int        cyc = 0;
    int        n_start = 0, n_zv = 0, n_xv = 0, n_yv = 0, n_fd = 0, n_tmo = 0, n_viol = 0;
    int        last_start_cyc = 0, tmo_gap = 0;
    logic [7:0] cmd_log [0:4095];
    logic      zv_d = 1'b0, xv_d = 1'b0, yv_d = 1'b0;

    always @(negedge cclk) begin
        cyc++;
        if (xfer_start && xfer_busy) n_viol++;
        if ((z_valid && zv_d) || (x_valid && xv_d) || (y_valid && yv_d)) n_viol++;
        zv_d = z_valid;
        xv_d = x_valid;
        yv_d = y_valid;
        if (timeout_err) begin
            n_tmo++;
            tmo_gap = cyc - last_start_cyc;
        end
        if (xfer_start) begin
            cmd_log[n_start % 4096] = xfer_cmd;
            n_start++;
            last_start_cyc = cyc;
        end
        if (z_valid) n_zv++;
        if (x_valid) n_xv++;
        if (y_valid) n_yv++;
        if (frame_done) n_fd++;
    end

    // Engine model: done 5 cycles after each start; only the 8th result of a channel run carries real data.
    int         pend_cd = 0, run = 0;
    logic       pend_drop = 1'b0, dropped = 1'b0;
    logic [11:0] pend_data = '0;
    logic [7:0] prev_cmd = '0;

    always begin
        @(posedge cclk);
        #1;
        eng_done = 1'b0;
        if (pend_cd != 0) begin
            pend_cd--;
            if (pend_cd == 0 && !pend_drop) begin
                eng_done = 1'b1;
                eng_data = pend_data;
            end
        end
        @(negedge cclk);
        if (rst) begin
            pend_cd  = 0;
            run      = 0;
            prev_cmd = '0;
            dropped  = 1'b0;
        end else if (xfer_start) begin
            if (xfer_cmd == prev_cmd) run++;
            else run = 1;
            prev_cmd  = xfer_cmd;
            pend_drop = withhold_x3 && !dropped && xfer_cmd == 8'hD3 && run == 3;
            if (pend_drop) begin
                dropped = 1'b1;
                run     = 0;
            end
            if (run == 8) begin
                case (xfer_cmd)
                    8'hB3:   pend_data = data_z;
                    8'hD3:   pend_data = data_x;
                    default: pend_data = data_y;
                endcase
            end else begin
                pend_data = 12'(12'h0A0 + run);
            end
            pend_cd = 5;
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        xfer_busy   = 1'b0;
        withhold_x3 = 1'b0;
        repeat (3) @(posedge cclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        for (int i = 0; i < 3000 && n_fd < target; i++) begin
            @(negedge cclk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge cclk);
        #1;
    endtask

    function automatic int count_cmd(input int from, input int to, input logic [7:0] cmd);
        int c = 0;
        for (int i = from; i < to; i++) if (cmd_log[i % 4096] == cmd) c++;
        return c;
    endfunction

    function automatic int order_errors(input int from);
        int bad = 0;
        logic [7:0] want;
        for (int i = 0; i < 24; i++) begin
            want = (i < 8) ? 8'hB3 : (i < 16) ? 8'hD3 : 8'h93;
            if (cmd_log[(from + i) % 4096] != want) bad++;
        end
        return bad;
    endfunction

    typedef struct {
        logic [11:0] z_in, x_in, y_in;
        logic [11:0] exp_x, exp_y;
        logic        exp_touched;
    } vec_t;

    vec_t vecs [4];

    int s_start, s_zv, s_xv, s_yv, s_fd, s_tmo;

    task automatic snap();
        s_start = n_start; s_zv = n_zv; s_xv = n_xv; s_yv = n_yv; s_fd = n_fd; s_tmo = n_tmo;
    endtask

    initial begin
`ifdef TOUCH_SCALE_EN
        vecs[0] = '{12'h200, 12'h200, 12'h200, 12'd116, 12'd72, 1'b1};
        vecs[2] = '{12'h100, 12'h291, 12'h357, 12'd153, 12'd115, 1'b1};
        vecs[3] = '{12'hFFF, 12'd100, 12'd50, 12'd25, 12'd20, 1'b1};
`else
        vecs[0] = '{12'h200, 12'h200, 12'h200, 12'h200, 12'h200, 1'b1};
        vecs[2] = '{12'h100, 12'h291, 12'h357, 12'h291, 12'h357, 1'b1};
        vecs[3] = '{12'hFFF, 12'd100, 12'd50, 12'd100, 12'd50, 1'b1};
`endif
        vecs[1] = '{12'h0FF, 12'h400, 12'h400, 12'h000, 12'h000, 1'b0};

        do_reset();
        idle_cycles(1);
        check("reset_outputs", {z_sample, x_sample, y_sample, z_valid, x_valid, y_valid,
                                touched, frame_done, timeout_err, xfer_start}, 64'd0);
        check("reset_cmd", xfer_cmd, 8'hB3);

        // One frame per vector, each from reset, enable pulsed for one cycle.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            data_z = vecs[i].z_in;
            data_x = vecs[i].x_in;
            data_y = vecs[i].y_in;
            snap();
            enable = 1'b1;
            @(posedge cclk);
            #1;
            enable = 1'b0;
            wait_fd(s_fd + 1);
            idle_cycles(20);
            check($sformatf("v%0d_starts", i), n_start - s_start, 24);
            check($sformatf("v%0d_cmd_order", i), order_errors(s_start), 0);
            check($sformatf("v%0d_z_valid", i), n_zv - s_zv, 1);
            check($sformatf("v%0d_x_valid", i), n_xv - s_xv, vecs[i].exp_touched ? 1 : 0);
            check($sformatf("v%0d_y_valid", i), n_yv - s_yv, vecs[i].exp_touched ? 1 : 0);
            check($sformatf("v%0d_frame_done", i), n_fd - s_fd, 1);
            check($sformatf("v%0d_z_sample", i), z_sample, vecs[i].z_in);
            check($sformatf("v%0d_x_sample", i), x_sample, vecs[i].exp_x);
            check($sformatf("v%0d_y_sample", i), y_sample, vecs[i].exp_y);
            check($sformatf("v%0d_touched", i), touched, vecs[i].exp_touched);
        end

        // Continuous enable: two frames, enable dropped during the third, which still completes.
        do_reset();
        data_z = 12'h200; data_x = 12'h200; data_y = 12'h200;
        snap();
        enable = 1'b1;
        wait_fd(s_fd + 2);
        enable = 1'b0;
        wait_fd(s_fd + 3);
        idle_cycles(20);
        check("cont_starts", n_start - s_start, 72);
        check("cont_frames", n_fd - s_fd, 3);
        check("cont_valids", {8'(n_zv - s_zv), 8'(n_xv - s_xv), 8'(n_yv - s_yv)}, {8'd3, 8'd3, 8'd3});

        // Withheld done on the 3rd X conversion: 1023 WAIT cycles, pulse one cycle later, X restarts.
        do_reset();
        withhold_x3 = 1'b1;
        snap();
        enable = 1'b1;
        @(posedge cclk);
        #1;
        enable = 1'b0;
        wait_fd(s_fd + 1);
        idle_cycles(20);
        check("tmo_pulses", n_tmo - s_tmo, 1);
        check("tmo_gap", tmo_gap, 1024);
        check("tmo_starts", n_start - s_start, 27);
        check("tmo_z_starts", count_cmd(s_start, n_start, 8'hB3), 8);
        check("tmo_x_starts", count_cmd(s_start, n_start, 8'hD3), 11);
        check("tmo_y_starts", count_cmd(s_start, n_start, 8'h93), 8);
        check("tmo_x_valid", n_xv - s_xv, 1);
        check("tmo_frame_done", n_fd - s_fd, 1);

        // Busy held for 20 cycles while the scheduler sits in ISSUE.
        do_reset();
        snap();
        enable = 1'b1;
        @(posedge cclk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 200 && !xfer_done; i++) begin
            @(negedge cclk);
            #1;
        end
        xfer_busy = 1'b1;
        s_start = n_start;
        repeat (20) @(posedge cclk);
        #1;
        check("busy_no_start", n_start - s_start, 0);
        xfer_busy = 1'b0;
        @(negedge cclk);
        #1;
        check("busy_release_start", n_start - s_start, 1);
        check("busy_release_cmd", cmd_log[(n_start - 1) % 4096], 8'hB3);
        wait_fd(s_fd + 1);
        idle_cycles(10);
        check("busy_frame_done", n_fd - s_fd, 1);

        // Enable dropped during the X slot: Y completes, then the block parks.
        do_reset();
        snap();
        enable = 1'b1;
        for (int i = 0; i < 500 && !(xfer_start && xfer_cmd == 8'hD3); i++) begin
            @(negedge cclk);
            #1;
        end
        enable = 1'b0;
        wait_fd(s_fd + 1);
        idle_cycles(5);
        check("en_drop_frame_done", n_fd - s_fd, 1);
        check("en_drop_y_valid", n_yv - s_yv, 1);
        s_start = n_start;
        idle_cycles(40);
        check("en_drop_parked", n_start - s_start, 0);

        // Reset asserted mid-WAIT, then a stray done while idle.
        do_reset();
        snap();
        enable = 1'b1;
        for (int i = 0; i < 500 && n_zv == s_zv; i++) begin
            @(negedge cclk);
            #1;
        end
        s_start = n_start;
        for (int i = 0; i < 100 && n_start == s_start; i++) begin
            @(negedge cclk);
            #1;
        end
        @(posedge cclk);
        #1;
        check("pre_rst_z", z_sample, 12'h200);
        rst    = 1'b1;
        enable = 1'b0;
        @(posedge cclk);
        #1;
        check("mid_rst_outputs", {z_sample, x_sample, y_sample, z_valid, x_valid, y_valid,
                                  touched, frame_done, timeout_err, xfer_start}, 64'd0);
        check("mid_rst_cmd", xfer_cmd, 8'hB3);
        rst = 1'b0;
        snap();
        @(posedge cclk);
        #1;
        stray_data = 12'hFFF;
        stray_done = 1'b1;
        @(posedge cclk);
        #1;
        stray_done = 1'b0;
        idle_cycles(15);
        check("stray_done_z", z_sample, 12'h000);
        check("stray_done_starts", n_start - s_start, 0);
        check("stray_done_valid", n_zv - s_zv, 0);

        check("protocol_violations", n_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
